hazard_sequencer: RTL
=====================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be as listed below (name, direction, width, meaning).
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous active-low reset
- Rs1D, Rs2D  in  5 each  decode-stage source registers
- Rs1E, Rs2E, RdE  in  5 each  execute-stage source and destination registers
- ResultSrcE  in  2  execute-stage result select; 01 = load
- PCSrcE  in  1  branch or jump taken in execute
- RdM, RegWriteM  in  5/1  memory-stage destination and write enable
- RdW, RegWriteW  in  5/1  writeback-stage destination and write enable
- halt_req, step_req, resume_req  in  1 each  debug requests, sampled on the clock edge
- StallF, StallD, FlushD, FlushE  out  1 each  pipeline-register controls
- ForwardAE, ForwardBE  out  2 each  forwarding selects: 00 = RF, 01 = ResultW, 10 = ALUResultM
- halted  out  1  high while in state HALTED
- seq_state  out  2  encoding: RUN = 00, DRAIN = 01, HALTED = 10, STEP = 11

Function
REQ-003 ForwardAE SHALL be 10 when RegWriteM is 1, RdM is nonzero and RdM equals Rs1E.
REQ-004 Otherwise, ForwardAE SHALL be 01 when RegWriteW is 1, RdW is nonzero and RdW equals Rs1E; in all other cases it SHALL be 00.
REQ-005 ForwardBE SHALL follow the same rules as REQ-003 and REQ-004, using Rs2E.
REQ-006 Forwarding SHALL be combinational and independent of seq_state.
REQ-007 lwStall SHALL be 1 when ResultSrcE is 01, RdE is nonzero, and RdE equals Rs1D or Rs2D.
REQ-008 In RUN, the outputs SHALL be: StallF = lwStall, StallD = lwStall, FlushD = PCSrcE, FlushE = lwStall OR PCSrcE.
REQ-009 In DRAIN and HALTED, StallF = 1, StallD = 1 and FlushE = 1 SHALL hold, so that bubbles enter execute.
REQ-010 In DRAIN only, when PCSrcE = 1, the outputs SHALL instead be StallF = 0, StallD = 0, FlushD = 1 and FlushE = 1, so that the branch target loads.
REQ-011 In STEP, the outputs SHALL equal the RUN equations for exactly one cycle, letting one instruction advance from decode to execute.
REQ-012 State transitions SHALL be:
- RUN --halt_req--> DRAIN
- DRAIN --drain counter = 2--> HALTED
- HALTED --resume_req--> RUN
- HALTED --step_req (with resume_req low)--> STEP
- STEP --unconditional--> DRAIN
REQ-013 A 2-bit drain counter SHALL clear on DRAIN entry and increment each DRAIN cycle, so DRAIN lasts exactly 3 cycles (execute, memory and writeback emptied).
REQ-014 If lwStall is 1 during STEP, the next state SHALL be STEP again (the step is retried) rather than DRAIN.
REQ-015 Simultaneous requests SHALL resolve as follows: in HALTED, resume_req beats step_req; halt_req SHALL be ignored outside RUN; step_req and resume_req SHALL be ignored outside HALTED.
REQ-016 halted SHALL be a registered decode of the HALTED state; seq_state SHALL be the state register.

Reset
REQ-017 When rst = 0, the block SHALL asynchronously set the state to RUN, the drain counter to 0, halted to 0, and all performance counters to 0.
REQ-018 A reset asserted in any state, including mid-DRAIN or STEP, SHALL return the block to RUN with no residual stall.
REQ-019 While in reset, the stall and flush outputs SHALL follow the RUN equations.

Configuration
REQ-020 With macro HAZARD_PERF_CNT_EN defined, the block SHALL add outputs stall_cnt (16 bits, counts cycles with lwStall = 1 in RUN) and flush_cnt (16 bits, counts cycles with PCSrcE = 1).
REQ-021 Both counters SHALL saturate at 0xFFFF and SHALL not count while halted is 1.
REQ-022 Without HAZARD_PERF_CNT_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-023 The bench SHALL check forwarding: RegWriteM = 1, RdM = 5, Rs1E = 5, with RdW = 5 and RegWriteW = 1 -> ForwardAE = 10; with RdM = 0 instead -> ForwardAE = 01.
REQ-024 The bench SHALL check load-use: ResultSrcE = 01, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 for one cycle; with RdE = 0 -> no stall.
REQ-025 The bench SHALL check halt: halt_req pulsed in RUN -> seq_state = 01 for 3 cycles, then halted = 1 and seq_state = 10, with StallF = StallD = FlushE = 1 throughout.
REQ-026 The bench SHALL check branch during DRAIN: PCSrcE = 1 in the first DRAIN cycle -> StallF = 0, FlushD = 1, FlushE = 1 that cycle, and HALTED is still reached after 3 DRAIN cycles.
REQ-027 The bench SHALL check step and resume: step_req in HALTED -> STEP for 1 cycle with StallD = 0, then DRAIN for 3 cycles, then HALTED; step_req and resume_req together -> RUN.
REQ-028 The bench SHALL check reset: rst = 0 during the 2nd DRAIN cycle -> seq_state = 00 and halted = 0 immediately, and with HAZARD_PERF_CNT_EN defined, stall_cnt = 0.

Source files
------------

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline hazard unit (forwarding, load-use stall, branch
// flush) with a debug run/drain/halt/step sequencer.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic [4:0] RdM,
  input  logic       RegWriteM,
  input  logic [4:0] RdW,
  input  logic       RegWriteW,
  input  logic       halt_req,
  input  logic       step_req,
  input  logic       resume_req,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       halted,
  output logic [1:0] seq_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam int unsigned DrainW = 2;
  localparam int unsigned CntW   = 16;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10,
    STEP   = 2'b11
  } seq_state_e;

  seq_state_e        state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              halted_q, halted_d;
  logic              lw_stall;

  // Forwarding selects: memory stage wins over writeback, x0 never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  // Load in execute whose destination feeds the instruction in decode.
  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // Sequencer next state and pipeline controls; RUN equations are the default.
  always_comb begin
    state_d = state_q;
    drain_d = '0;
    StallF  = lw_stall;
    StallD  = lw_stall;
    FlushD  = PCSrcE;
    FlushE  = lw_stall | PCSrcE;
    unique case (state_q)
      RUN: begin
        if (halt_req) state_d = DRAIN;
      end
      DRAIN: begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        FlushD  = 1'b0;
        FlushE  = 1'b1;
        // A taken branch still in flight must redirect fetch.
        if (PCSrcE) begin
          StallF = 1'b0;
          StallD = 1'b0;
          FlushD = 1'b1;
        end
        drain_d = drain_q + DrainW'(1);
        if (drain_q == DrainW'(2)) state_d = HALTED;
      end
      HALTED: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b1;
        if (resume_req)    state_d = RUN;
        else if (step_req) state_d = STEP;
      end
      STEP: begin
        // Retry the step while the stepped instruction is load-use blocked.
        if (lw_stall) state_d = STEP;
        else          state_d = DRAIN;
      end
      default: state_d = RUN;
    endcase
    halted_d = (state_d == HALTED);
  end

  // Sequencer state, drain counter and halted flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      drain_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= halted_d;
    end
  end

  assign halted    = halted_q;
  assign seq_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CntW-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters, frozen while halted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!halted_q) begin
      if ((state_q == RUN) && lw_stall && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + CntW'(1);
      if (PCSrcE && (flush_cnt_q != '1))
        flush_cnt_d = flush_cnt_q + CntW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
